// File: rtl/bsw_band_tracker.sv
// rtl/bsw_band_tracker.sv - best-score / band-offset tracker behind the 16-PE max comparator (optional X-drop: BSW_XDROP_EN)
module bsw_band_tracker #(
  parameter int H_W   = 7,
  parameter int P_W   = 4,
  parameter int CNT_W = 10
`ifdef BSW_XDROP_EN
  ,
  parameter int XDROP = 20
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [H_W-1:0]   ma_out,
  input  logic [P_W-1:0]   ma_p,
  input  logic             r_shift_sig,
  input  logic             d_shift_sig,
  output logic             shift_r,
  output logic             shift_d,
  output logic [H_W-1:0]   best_score,
  output logic [CNT_W-1:0] best_step,
  output logic [P_W-1:0]   best_pe,
  output logic [CNT_W-1:0] best_off,
  output logic [CNT_W-1:0] band_off,
  output logic             busy,
  output logic             done,
  output logic             xdrop_hit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Saturation limits; band_off is two's complement in CNT_W bits.
  localparam logic [CNT_W-1:0] STEP_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] OFF_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] OFF_MIN  = {1'b1, {(CNT_W-1){1'b0}}};

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] step;
  logic             accept;
  logic             better;
  logic             want_r;
  logic             want_d;
  logic             xdrop;
  logic             xdrop_hit_q;

  // start always wins, so a step arriving with start is dropped.
  assign accept = (state == S_RUN) && in_valid && !start;
  assign better = ma_out > best_score;
  assign want_r = r_shift_sig && !d_shift_sig;
  assign want_d = d_shift_sig && !r_shift_sig;

`ifdef BSW_XDROP_EN
  localparam logic [H_W:0] XDROP_THR = (H_W+1)'(XDROP);
  logic [H_W:0] gap;
  // One extra bit keeps the difference from wrapping.
  assign gap       = {1'b0, best_score} - {1'b0, ma_out};
  assign xdrop     = accept && (best_score > ma_out) && (gap > XDROP_THR);
  assign xdrop_hit = xdrop_hit_q;
`else
  assign xdrop     = 1'b0;
  assign xdrop_hit = 1'b0;
`endif

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: start restarts from anywhere; last step or X-drop ends the run.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        if (start)                           state_nx = S_RUN;
        else if (xdrop)                      state_nx = S_DONE;
        else if (in_valid && in_last)        state_nx = S_DONE;
      end
      S_DONE: begin
        if (start) state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Tracker datapath: best-score capture, step count, band offset and shift pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r     <= 1'b0;
      shift_d     <= 1'b0;
      best_score  <= '0;
      best_step   <= '0;
      best_pe     <= '0;
      best_off    <= '0;
      band_off    <= '0;
      step        <= '0;
      xdrop_hit_q <= 1'b0;
    end else begin
      shift_r <= 1'b0;
      shift_d <= 1'b0;
      if (start) begin
        best_score  <= '0;
        best_step   <= '0;
        best_pe     <= '0;
        best_off    <= '0;
        band_off    <= '0;
        step        <= '0;
        xdrop_hit_q <= 1'b0;
      end else if (accept) begin
        if (xdrop) begin
          // Terminating step: best_* held, no shift, offset frozen.
          xdrop_hit_q <= 1'b1;
        end else begin
          if (better) begin
            best_score <= ma_out;
            best_step  <= step;
            best_pe    <= ma_p;
            best_off   <= band_off;
          end
          if (step != STEP_MAX) begin
            step <= step + CNT_W'(1);
          end
          if (want_r) begin
            shift_r <= 1'b1;
            if (band_off != OFF_MAX) band_off <= band_off + CNT_W'(1);
          end else if (want_d) begin
            shift_d <= 1'b1;
            if (band_off != OFF_MIN) band_off <= band_off - CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bsw_band_tracker.sv
// tb/tb_bsw_band_tracker.sv - randomized + directed check of bsw_band_tracker against a behavioural model
module tb_bsw_band_tracker;

  localparam int H_W   = 7;
  localparam int P_W   = 4;
  localparam int CNT_W = 4;
  localparam int XDROP = 20;
`ifdef BSW_XDROP_EN
  localparam bit XD_EN = 1'b1;
`else
  localparam bit XD_EN = 1'b0;
`endif
  localparam int OFF_HI  = (1 << (CNT_W-1)) - 1;
  localparam int OFF_LO  = -(1 << (CNT_W-1));
  localparam int STEP_HI = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [H_W-1:0]   ma_out = '0;
  logic [P_W-1:0]   ma_p = '0;
  logic             r_shift_sig = 1'b0;
  logic             d_shift_sig = 1'b0;
  logic             shift_r, shift_d, busy, done, xdrop_hit;
  logic [H_W-1:0]   best_score;
  logic [CNT_W-1:0] best_step, best_off, band_off;
  logic [P_W-1:0]   best_pe;

  bsw_band_tracker #(.H_W(H_W), .P_W(P_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_last(in_last),
    .ma_out(ma_out), .ma_p(ma_p), .r_shift_sig(r_shift_sig), .d_shift_sig(d_shift_sig),
    .shift_r(shift_r), .shift_d(shift_d), .best_score(best_score), .best_step(best_step),
    .best_pe(best_pe), .best_off(best_off), .band_off(band_off), .busy(busy),
    .done(done), .xdrop_hit(xdrop_hit)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state, plain integers.
  bit m_run, m_done, m_xhit, m_sr, m_sd;
  int m_best, m_bstep, m_bpe, m_boff, m_off, m_step;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    m_best = 0; m_bstep = 0; m_bpe = 0; m_boff = 0; m_off = 0; m_step = 0;
    m_xhit = 0; m_sr = 0; m_sd = 0;
  endtask

  // One clock edge of the alignment tracker, computed from the rules directly.
  task automatic model_edge();
    int ma;
    m_sr = 0; m_sd = 0;
    ma = int'(ma_out);
    if (reset) begin
      model_clear(); m_run = 0; m_done = 0;
    end else if (start) begin
      model_clear(); m_run = 1; m_done = 0;
    end else if (m_run && in_valid) begin
      if (XD_EN && m_best > ma && (m_best - ma) > XDROP) begin
        m_run = 0; m_done = 1; m_xhit = 1;
      end else begin
        if (ma > m_best) begin
          m_best = ma; m_bstep = m_step; m_bpe = int'(ma_p); m_boff = m_off;
        end
        if (r_shift_sig && !d_shift_sig) begin
          m_sr = 1; if (m_off < OFF_HI) m_off++;
        end
        if (d_shift_sig && !r_shift_sig) begin
          m_sd = 1; if (m_off > OFF_LO) m_off--;
        end
        if (m_step < STEP_HI) m_step++;
        if (in_last) begin m_run = 0; m_done = 1; end
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".busy"},      int'(busy),      int'(m_run));
    chk({ph, ".done"},      int'(done),      int'(m_done));
    chk({ph, ".xdrop_hit"}, int'(xdrop_hit), int'(m_xhit));
    chk({ph, ".shift_r"},   int'(shift_r),   int'(m_sr));
    chk({ph, ".shift_d"},   int'(shift_d),   int'(m_sd));
    chk({ph, ".best_score"}, int'(best_score), m_best);
    chk({ph, ".best_step"}, int'(best_step), m_bstep);
    chk({ph, ".best_pe"},   int'(best_pe),   m_bpe);
    chk({ph, ".best_off"},  int'($signed(best_off)), m_boff);
    chk({ph, ".band_off"},  int'($signed(band_off)), m_off);
  endtask

  // Inputs are applied at the falling edge, model advances on the rising edge, outputs compared at the next falling edge.
  task automatic cyc(input string ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic drive(input bit st, input bit v, input bit l, input int ma, input int p,
                       input bit r, input bit d);
    start = st; in_valid = v; in_last = l;
    ma_out = H_W'(ma); ma_p = P_W'(p); r_shift_sig = r; d_shift_sig = d;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  int cnt_r;
  int tv_sc [4] = '{5, 9, 9, 3};
  int tv_pe [4] = '{2, 7, 11, 0};
  int t3_sc [4] = '{1, 2, 10, 4};
  bit t3_r  [4] = '{1, 1, 0, 1};
  bit t3_d  [4] = '{0, 0, 1, 1};

  initial begin
    m_run = 0; m_done = 0; model_clear();
    // Power-on reset.
    @(negedge clk); reset = 1'b1;
    cyc("por");
    reset = 1'b0;
    cyc("post_por");

    // 1. Reset mid-run, then in_valid without start is ignored.
    drive(1, 0, 0, 0, 0, 0, 0); cyc("t1_start");
    drive(0, 1, 0, 33, 3, 1, 0); cyc("t1_step0");
    drive(0, 1, 0, 50, 5, 1, 0); cyc("t1_step1");
    reset = 1'b1; #1;
    m_run = 0; m_done = 0; model_clear();
    check_all("t1_async");
    idle_in(); @(negedge clk); cyc("t1_hold");
    reset = 1'b0;
    drive(0, 1, 0, 60, 4, 1, 0); cyc("t1_ignored0");
    drive(0, 1, 1, 61, 4, 0, 1); cyc("t1_ignored1");
    chk("t1_busy_idle", int'(busy), 0);
    chk("t1_score_idle", int'(best_score), 0);

    // 2. Max with tie: earliest step keeps it.
    drive(1, 1, 0, 99, 9, 1, 0); cyc("t2_start");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, tv_sc[i], tv_pe[i], 0, 0); cyc("t2_step");
    end
    chk("t2_best_score", int'(best_score), 9);
    chk("t2_best_step", int'(best_step), 1);
    chk("t2_best_pe", int'(best_pe), 7);

    // 3 + 4. Shift decode, best_off latch, in_last on the fourth step, restart.
    idle_in(); start = 1'b1; cyc("t3_start");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i == 3), t3_sc[i], i, t3_r[i], t3_d[i]); cyc("t3_step");
      chk("t3_pulse_r", int'(shift_r), int'(t3_r[i] && !t3_d[i]));
      chk("t3_pulse_d", int'(shift_d), int'(t3_d[i] && !t3_r[i]));
    end
    chk("t3_band_off", int'($signed(band_off)), 1);
    chk("t3_best_off", int'($signed(best_off)), 2);
    chk("t4_done", int'(done), 1);
    chk("t4_busy", int'(busy), 0);
    drive(0, 1, 0, 120, 1, 1, 0); cyc("t4_after_done");
    chk("t4_no_pulse", int'(shift_r), 0);
    chk("t4_score_kept", int'(best_score), 10);
    drive(1, 0, 0, 0, 0, 0, 0); cyc("t4_restart");
    chk("t4_cleared", int'(best_score), 0);
    chk("t4_busy_again", int'(busy), 1);

    // 5. Offset saturation at +7 with CNT_W=4; every R still pulses.
    cnt_r = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, i, 0, 1, 0); cyc("t5_step");
      if (shift_r) cnt_r++;
    end
    chk("t5_band_off", int'($signed(band_off)), 7);
    chk("t5_pulses", cnt_r, 10);

`ifdef BSW_XDROP_EN
    // 6. X-drop boundary: gap 21 terminates, gap 20 does not.
    drive(1, 0, 0, 0, 0, 0, 0); cyc("t6_start");
    drive(0, 1, 0, 40, 1, 0, 0); cyc("t6_s0");
    drive(0, 1, 0, 19, 2, 1, 0); cyc("t6_s1");
    chk("t6_xhit", int'(xdrop_hit), 1);
    chk("t6_done", int'(done), 1);
    chk("t6_best", int'(best_score), 40);
    chk("t6_no_pulse", int'(shift_r), 0);
    drive(1, 0, 0, 0, 0, 0, 0); cyc("t6_restart");
    drive(0, 1, 0, 40, 1, 0, 0); cyc("t6b_s0");
    drive(0, 1, 0, 20, 2, 0, 0); cyc("t6b_s1");
    chk("t6b_no_xhit", int'(xdrop_hit), 0);
    chk("t6b_busy", int'(busy), 1);
`endif

    // Randomized traffic including restarts, ignored inputs and async resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle_in(); reset = 1'b1; cyc("rnd_reset"); reset = 1'b0;
      end
      drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
